// File: rtl/ob_pkg.sv
// ob_pkg: shared types and constants for the order book block.
// The definitions below serve the response serialiser (ob_rsp_ser):
//   rsp_t               - response word produced by ob
//   rsp_ser_state_t     - frame FSM state encoding
//   RSP_SER_SYNC_BYTE   - first byte of every egress frame
//   rsp_ser_len()       - payload byte count for a word of a given width
//   rsp_ser_frame_cnt_t - completed-frame counter type
package ob_pkg;

    typedef struct packed {
        logic [3:0]  kind;
        logic [15:0] order_id;
        logic [15:0] qty;
    } rsp_t;

    typedef enum logic [2:0] {
        RSP_SER_IDLE = 3'd0,
        RSP_SER_SYNC = 3'd1,
        RSP_SER_LEN  = 3'd2,
        RSP_SER_BODY = 3'd3,
        RSP_SER_CSUM = 3'd4
    } rsp_ser_state_t;

    localparam logic [7:0] RSP_SER_SYNC_BYTE = 8'hA5;

    typedef logic [31:0] rsp_ser_frame_cnt_t;

    // Number of whole bytes needed to carry a word of the given width.
    function automatic int rsp_ser_len(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/ob_rsp_ser.sv
// ob_rsp_ser: egress transmitter for ob responses.
// Takes one response word per rsp_vld/rsp_accept handshake and emits it on a
// byte-wide link as a frame: SYNC_BYTE, LEN, payload (MSB first), CSUM,
// where CSUM is the XOR of LEN and all payload bytes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   rsp_vld, rsp    - response word from ob (held until accepted)
//   rsp_accept      - response consumed this cycle (combinational)
//   tx_vld/tx_data  - byte stream, transferred when tx_vld & tx_accept
//   tx_sop, tx_eop  - marks the sync byte / the checksum byte
//   tx_accept       - downstream ready
//   tx_busy_r       - a frame is in progress
//   tx_frame_cnt_r  - completed frames (wraps)
module ob_rsp_ser
    import ob_pkg::*;
#(
    parameter int         RSP_W     = $bits(rsp_t),
    parameter logic [7:0] SYNC_BYTE = RSP_SER_SYNC_BYTE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rsp_vld,
    input  logic [RSP_W-1:0]         rsp,
    output logic                     rsp_accept,
    output logic                     tx_vld,
    output logic [7:0]               tx_data,
    output logic                     tx_sop,
    output logic                     tx_eop,
    input  logic                     tx_accept,
    output logic                     tx_busy_r,
    output rsp_ser_frame_cnt_t       tx_frame_cnt_r
);

    localparam int         N        = rsp_ser_len(RSP_W);
    localparam int         PW       = 8 * N;
    localparam int         CW       = $clog2(N + 1);
    localparam logic [7:0] LEN_BYTE = 8'(N);

    localparam logic [2:0] ST_IDLE = RSP_SER_IDLE;
    localparam logic [2:0] ST_SYNC = RSP_SER_SYNC;
    localparam logic [2:0] ST_LEN  = RSP_SER_LEN;
    localparam logic [2:0] ST_BODY = RSP_SER_BODY;
    localparam logic [2:0] ST_CSUM = RSP_SER_CSUM;

    // The LEN byte is only 8 bits wide, so longer payloads cannot be framed.
    if (N > 255) begin : g_len_check
        $error("ob_rsp_ser: RSP_W gives more than 255 payload bytes");
    end

    logic [2:0]    state, state_n;
    logic [PW-1:0] payload, payload_n;
    logic [7:0]    csum, csum_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [7:0]    data_n;
    logic          capture;
    logic          frame_done;

    // A new word can enter when idle, or on the very cycle the checksum
    // byte leaves, which lets frames run back to back without a bubble.
    assign rsp_accept = (state == ST_IDLE) | ((state == ST_CSUM) & tx_accept);
    assign capture    = rsp_vld & rsp_accept;

    // Next-state logic. The payload register always holds the next body byte
    // in its top 8 bits, so the body is sent by shifting left once per byte.
    always_comb begin
        state_n    = state;
        payload_n  = payload;
        csum_n     = csum;
        cnt_n      = cnt;
        frame_done = 1'b0;
        case (state)
            ST_SYNC: begin
                if (tx_accept) begin
                    state_n = ST_LEN;
                    csum_n  = LEN_BYTE;
                end
            end
            ST_LEN: begin
                if (tx_accept) begin
                    state_n = ST_BODY;
                    cnt_n   = '0;
                end
            end
            ST_BODY: begin
                if (tx_accept) begin
                    csum_n    = csum ^ payload[PW-1 -: 8];
                    payload_n = payload << 8;
                    cnt_n     = cnt + CW'(1);
                    if (cnt == CW'(N - 1)) begin
                        state_n = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (tx_accept) begin
                    frame_done = 1'b1;
                    state_n    = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Capture overrides the above; it can only happen from IDLE or at
        // the CSUM hand-off, where the old frame is already finished.
        if (capture) begin
            state_n   = ST_SYNC;
            payload_n = PW'(rsp);
            csum_n    = '0;
        end
    end

    // Output byte for the state being entered. Computing it from the next
    // state lets the link outputs be plain registers, and they stay stable
    // while the downstream stalls because nothing advances without tx_accept.
    always_comb begin
        data_n = 8'h00;
        case (state_n)
            ST_SYNC: data_n = SYNC_BYTE;
            ST_LEN:  data_n = LEN_BYTE;
            ST_BODY: data_n = payload_n[PW-1 -: 8];
            ST_CSUM: data_n = csum_n;
            default: data_n = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            payload        <= '0;
            csum           <= '0;
            cnt            <= '0;
            tx_vld         <= 1'b0;
            tx_data        <= 8'h00;
            tx_sop         <= 1'b0;
            tx_eop         <= 1'b0;
            tx_busy_r      <= 1'b0;
            tx_frame_cnt_r <= '0;
        end else begin
            state     <= state_n;
            payload   <= payload_n;
            csum      <= csum_n;
            cnt       <= cnt_n;
            tx_vld    <= (state_n != ST_IDLE);
            tx_data   <= data_n;
            tx_sop    <= (state_n == ST_SYNC);
            tx_eop    <= (state_n == ST_CSUM);
            tx_busy_r <= (state_n != ST_IDLE);
            if (frame_done) begin
                tx_frame_cnt_r <= tx_frame_cnt_r + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_ob_rsp_ser.sv
// tb_ob_rsp_ser: scoreboard bench for ob_rsp_ser.
// Three instances share clock and reset: RSP_W=16, RSP_W=12 and the default
// rsp_t width. Expected frame bytes are queued when a response is issued and
// a per-instance monitor pops and compares every transferred byte.
module tb_ob_rsp_ser;
    import ob_pkg::*;

    localparam int DW = $bits(rsp_t);
    localparam int ND = (DW + 7) / 8;

    typedef struct packed {
        logic       sop;
        logic       eop;
        logic [7:0] data;
    } exp_byte_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    logic        s16_rsp_vld, s16_rsp_accept, s16_tx_vld, s16_tx_sop, s16_tx_eop;
    logic        s16_tx_accept, s16_tx_busy_r;
    logic [15:0] s16_rsp;
    logic [7:0]  s16_tx_data;
    logic [31:0] s16_frame_cnt;

    logic        s12_rsp_vld, s12_rsp_accept, s12_tx_vld, s12_tx_sop, s12_tx_eop;
    logic        s12_tx_accept, s12_tx_busy_r;
    logic [11:0] s12_rsp;
    logic [7:0]  s12_tx_data;
    logic [31:0] s12_frame_cnt;

    logic          sd_rsp_vld, sd_rsp_accept, sd_tx_vld, sd_tx_sop, sd_tx_eop;
    logic          sd_tx_accept, sd_tx_busy_r;
    logic [DW-1:0] sd_rsp;
    logic [7:0]    sd_tx_data;
    logic [31:0]   sd_frame_cnt;

    exp_byte_t q16[$];
    exp_byte_t q12[$];
    exp_byte_t qd[$];

    int cmp_count  = 0;
    int fail_count = 0;

    ob_rsp_ser #(.RSP_W(16)) u16 (
        .clk(clk), .rst(rst), .rsp_vld(s16_rsp_vld), .rsp(s16_rsp),
        .rsp_accept(s16_rsp_accept), .tx_vld(s16_tx_vld), .tx_data(s16_tx_data),
        .tx_sop(s16_tx_sop), .tx_eop(s16_tx_eop), .tx_accept(s16_tx_accept),
        .tx_busy_r(s16_tx_busy_r), .tx_frame_cnt_r(s16_frame_cnt)
    );

    ob_rsp_ser #(.RSP_W(12)) u12 (
        .clk(clk), .rst(rst), .rsp_vld(s12_rsp_vld), .rsp(s12_rsp),
        .rsp_accept(s12_rsp_accept), .tx_vld(s12_tx_vld), .tx_data(s12_tx_data),
        .tx_sop(s12_tx_sop), .tx_eop(s12_tx_eop), .tx_accept(s12_tx_accept),
        .tx_busy_r(s12_tx_busy_r), .tx_frame_cnt_r(s12_frame_cnt)
    );

    ob_rsp_ser ud (
        .clk(clk), .rst(rst), .rsp_vld(sd_rsp_vld), .rsp(sd_rsp),
        .rsp_accept(sd_rsp_accept), .tx_vld(sd_tx_vld), .tx_data(sd_tx_data),
        .tx_sop(sd_tx_sop), .tx_eop(sd_tx_eop), .tx_accept(sd_tx_accept),
        .tx_busy_r(sd_tx_busy_r), .tx_frame_cnt_r(sd_frame_cnt)
    );

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name, input logic [63:0] act);
        cmp_count++;
        fail_count++;
        $display("[TB] FAIL %s: got %0h, nothing expected", name, act);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed five-byte frame for the 16- and 12-bit instances.
    task automatic push_frame5(input int which, input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
        exp_byte_t f[5];
        f[0] = '{sop: 1'b1, eop: 1'b0, data: b0};
        f[1] = '{sop: 1'b0, eop: 1'b0, data: b1};
        f[2] = '{sop: 1'b0, eop: 1'b0, data: b2};
        f[3] = '{sop: 1'b0, eop: 1'b0, data: b3};
        f[4] = '{sop: 1'b0, eop: 1'b1, data: b4};
        for (int i = 0; i < 5; i++) begin
            if (which == 16) q16.push_back(f[i]);
            else             q12.push_back(f[i]);
        end
    endtask

    // Reference frame for the default-width instance.
    task automatic push_frame_default(input logic [DW-1:0] v);
        logic [8*ND-1:0] p;
        logic [7:0]      c;
        logic [7:0]      b;
        p = (8*ND)'(v);
        c = 8'(ND);
        qd.push_back('{sop: 1'b1, eop: 1'b0, data: 8'hA5});
        qd.push_back('{sop: 1'b0, eop: 1'b0, data: 8'(ND)});
        for (int i = ND - 1; i >= 0; i--) begin
            b = p[8*i +: 8];
            c = c ^ b;
            qd.push_back('{sop: 1'b0, eop: 1'b0, data: b});
        end
        qd.push_back('{sop: 1'b0, eop: 1'b1, data: c});
    endtask

    function automatic logic busy_of(input int which);
        if (which == 16) return s16_tx_busy_r;
        if (which == 12) return s12_tx_busy_r;
        return sd_tx_busy_r;
    endfunction

    task automatic wait_idle(input int which, input string name);
        int n;
        n = 0;
        while (busy_of(which) && n < 200) begin
            step();
            n++;
        end
        if (n >= 200) flag_fail({name, " idle timeout"}, 64'(n));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // Issue one response to the default instance and wait for its handshake.
    // Sampling happens at +3 after the edge, after the backpressure driver.
    task automatic apply_stimulus(input logic [DW-1:0] v);
        int   n;
        logic acc;
        push_frame_default(v);
        sd_rsp     = v;
        sd_rsp_vld = 1'b1;
        n = 0;
        do begin
            acc = sd_rsp_accept;
            @(posedge clk);
            #3;
            n++;
        end while (!acc && n < 300);
        if (!acc) flag_fail("default rsp_accept timeout", 64'(n));
    endtask

    // Byte monitors: every transferred byte must be the next queued one.
    always @(negedge clk) begin
        if (!rst && s16_tx_vld && s16_tx_accept) begin
            if (q16.size() == 0) flag_fail("u16 extra byte", 64'(s16_tx_data));
            else check_output("u16 byte", 64'({s16_tx_sop, s16_tx_eop, s16_tx_data}), 64'(q16.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && s12_tx_vld && s12_tx_accept) begin
            if (q12.size() == 0) flag_fail("u12 extra byte", 64'(s12_tx_data));
            else check_output("u12 byte", 64'({s12_tx_sop, s12_tx_eop, s12_tx_data}), 64'(q12.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (!rst && sd_tx_vld && sd_tx_accept) begin
            if (qd.size() == 0) flag_fail("default extra byte", 64'(sd_tx_data));
            else check_output("default byte", 64'({sd_tx_sop, sd_tx_eop, sd_tx_data}), 64'(qd.pop_front()));
        end
    end

    // Random backpressure on the default instance, mostly accepting.
    always begin
        @(posedge clk);
        #2;
        sd_tx_accept = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        s16_rsp_vld = 1'b0; s16_rsp = '0; s16_tx_accept = 1'b0;
        s12_rsp_vld = 1'b0; s12_rsp = '0; s12_tx_accept = 1'b0;
        sd_rsp_vld  = 1'b0; sd_rsp  = '0; sd_tx_accept  = 1'b0;
        step();
        step();

        // Reset values, still inside reset.
        check_output("reset tx_vld",    64'(s16_tx_vld),    64'd0);
        check_output("reset tx_sop",    64'(s16_tx_sop),    64'd0);
        check_output("reset tx_eop",    64'(s16_tx_eop),    64'd0);
        check_output("reset tx_data",   64'(s16_tx_data),   64'd0);
        check_output("reset tx_busy_r", 64'(s16_tx_busy_r), 64'd0);
        check_output("reset frame_cnt", 64'(s16_frame_cnt), 64'd0);
        rst = 1'b0;
        check_output("idle rsp_accept", 64'(s16_rsp_accept), 64'd1);

        // Basic 16-bit frame with first byte one cycle after the accept.
        s16_tx_accept = 1'b1;
        push_frame5(16, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
        s16_rsp = 16'h1234;
        s16_rsp_vld = 1'b1;
        step();
        s16_rsp_vld = 1'b0;
        check_output("latency tx_vld", 64'(s16_tx_vld), 64'd1);
        check_output("latency sync byte", 64'({s16_tx_sop, s16_tx_data}), 64'({1'b1, 8'hA5}));
        check_output("sync rsp_accept", 64'(s16_rsp_accept), 64'd0);
        check_output("sync tx_busy_r", 64'(s16_tx_busy_r), 64'd1);
        wait_idle(16, "basic16");
        check_output("basic16 frame_cnt", 64'(s16_frame_cnt), 64'd1);

        // 12-bit word: upper nibble of the first payload byte is padding.
        s12_tx_accept = 1'b1;
        push_frame5(12, 8'hA5, 8'h02, 8'h0A, 8'hBC, 8'hB4);
        s12_rsp = 12'hABC;
        s12_rsp_vld = 1'b1;
        step();
        s12_rsp_vld = 1'b0;
        wait_idle(12, "pad12");
        check_output("pad12 frame_cnt", 64'(s12_frame_cnt), 64'd1);

        // Downstream stall for three cycles on byte 12.
        push_frame5(16, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
        s16_rsp = 16'h1234;
        s16_rsp_vld = 1'b1;
        step();
        s16_rsp_vld = 1'b0;
        step();
        step();
        s16_tx_accept = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("stall tx_vld", 64'(s16_tx_vld), 64'd1);
            check_output("stall tx_data", 64'(s16_tx_data), 64'h12);
            check_output("stall rsp_accept", 64'(s16_rsp_accept), 64'd0);
            step();
        end
        s16_tx_accept = 1'b1;
        wait_idle(16, "stall16");
        check_output("stall16 frame_cnt", 64'(s16_frame_cnt), 64'd2);

        // Back-to-back frames with no idle byte between them.
        do_reset();
        push_frame5(16, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
        push_frame5(16, 8'hA5, 8'h02, 8'h00, 8'hFF, 8'hFD);
        s16_rsp = 16'h1234;
        s16_rsp_vld = 1'b1;
        step();
        s16_rsp = 16'h00FF;
        for (int i = 0; i < 10; i++) begin
            check_output("b2b tx_vld", 64'(s16_tx_vld), 64'd1);
            if (i < 4) check_output("b2b rsp_accept low", 64'(s16_rsp_accept), 64'd0);
            if (i == 4) check_output("b2b rsp_accept at eop", 64'({s16_rsp_accept, s16_tx_eop}), 64'h3);
            step();
            if (i == 4) s16_rsp_vld = 1'b0;
        end
        wait_idle(16, "b2b16");
        check_output("b2b frame_cnt", 64'(s16_frame_cnt), 64'd2);

        // Reset while byte 34 is on the link abandons the frame.
        do_reset();
        push_frame5(16, 8'hA5, 8'h02, 8'h12, 8'h34, 8'h24);
        void'(q16.pop_back());
        void'(q16.pop_back());
        s16_rsp = 16'h1234;
        s16_rsp_vld = 1'b1;
        step();
        s16_rsp_vld = 1'b0;
        step();
        step();
        step();
        check_output("pre-reset byte", 64'(s16_tx_data), 64'h34);
        s16_tx_accept = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midreset tx_vld", 64'(s16_tx_vld), 64'd0);
        check_output("midreset tx_busy_r", 64'(s16_tx_busy_r), 64'd0);
        check_output("midreset frame_cnt", 64'(s16_frame_cnt), 64'd0);
        check_output("midreset queue drained", 64'(q16.size()), 64'd0);
        s16_tx_accept = 1'b1;
        push_frame5(16, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h03);
        s16_rsp = 16'h0001;
        s16_rsp_vld = 1'b1;
        step();
        s16_rsp_vld = 1'b0;
        wait_idle(16, "after reset");
        check_output("after reset frame_cnt", 64'(s16_frame_cnt), 64'd1);

        // Default width under random backpressure.
        #2;
        apply_stimulus('1);
        for (int k = 0; k < 8; k++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            apply_stimulus(r[DW-1:0]);
        end
        sd_rsp_vld = 1'b0;
        step();
        wait_idle(0, "default");
        check_output("default frame_cnt", 64'(sd_frame_cnt), 64'd9);

        check_output("u16 queue empty", 64'(q16.size()), 64'd0);
        check_output("u12 queue empty", 64'(q12.size()), 64'd0);
        check_output("default queue empty", 64'(qd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
